// File: rtl/ustc_stream_array.sv
// Streaming sparse PE array: a stationary A tile multiplied against B vectors routed through
// a Benes network, reduced by a FAN adder tree and accumulated over K-folds per tile.
module ustc_stream_array #(
  parameter int N_UNIT    = 32,
  parameter int DW_DATA   = 32,
  parameter int TILE_K    = 8,
  parameter int N_ADDERS  = N_UNIT - 1,
  parameter int N_BUSLINE = 2 * N_ADDERS,
  parameter int N_LEVELS  = 2 * $clog2(N_UNIT) - 1,
  parameter int FOLD_W    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [N_LEVELS*N_UNIT-1:0]     cfg_route,
  input  logic [N_ADDERS-1:0]            cfg_add_en,
  input  logic [N_ADDERS-1:0]            cfg_bypass_en,
  input  logic [6*N_ADDERS-1:0]          cfg_sel,
  input  logic [2*N_UNIT-1:0]            cfg_edge_tag,
  input  logic [FOLD_W-1:0]              cfg_folds,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [N_UNIT*DW_DATA-1:0]      a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [TILE_K*DW_DATA-1:0]      b_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_BUSLINE*DW_DATA-1:0]   out_bus,
  output logic [N_BUSLINE-1:0]           out_mask,
  output logic                           busy
);

  localparam int LOG_N = $clog2(N_UNIT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_A, S_STREAM, S_DRAIN} state_t;

  typedef struct packed {
    logic [N_LEVELS*N_UNIT-1:0] route;
    logic [N_ADDERS-1:0]        add_en;
    logic [N_ADDERS-1:0]        bypass_en;
    logic [6*N_ADDERS-1:0]      sel;
    logic [2*N_UNIT-1:0]        edge_tag;
    logic [FOLD_W-1:0]          folds;
  } cfg_t;

  // Benes network as butterfly + inverse butterfly; level l exchanges ports differing in
  // one index bit, and the switch is controlled by the route bit of the lower port.
  function automatic logic [N_UNIT*DW_DATA-1:0] benes_route(
    input logic [TILE_K*DW_DATA-1:0]  b,
    input logic [N_LEVELS*N_UNIT-1:0] route
  );
    logic [N_UNIT*DW_DATA-1:0] cur;
    logic [N_UNIT*DW_DATA-1:0] nxt;
    int d;
    int lo;
    for (int i = 0; i < N_UNIT; i++)
      cur[i*DW_DATA +: DW_DATA] = b[(i % TILE_K)*DW_DATA +: DW_DATA];
    for (int l = 0; l < N_LEVELS; l++) begin
      d = (l < LOG_N) ? (LOG_N - 1 - l) : (l - LOG_N + 1);
      for (int i = 0; i < N_UNIT; i++) begin
        lo = i & ~(1 << d);
        if (route[l*N_UNIT + lo])
          nxt[i*DW_DATA +: DW_DATA] = cur[(i ^ (1 << d))*DW_DATA +: DW_DATA];
        else
          nxt[i*DW_DATA +: DW_DATA] = cur[i*DW_DATA +: DW_DATA];
      end
      cur = nxt;
    end
    return cur;
  endfunction

  function automatic logic signed [DW_DATA-1:0] wrap_mul(
    input logic signed [DW_DATA-1:0] x,
    input logic signed [DW_DATA-1:0] y
  );
    return x * y;
  endfunction

  function automatic logic signed [DW_DATA-1:0] wrap_add(
    input logic signed [DW_DATA-1:0] x,
    input logic signed [DW_DATA-1:0] y
  );
    return x + y;
  endfunction

  // FAN tree in heap order: adder k is node k+1, nodes >= N_UNIT are multiplier leaves.
  // Invalid nodes always carry 0. Lane 2k is the adder result (emitted when sel[6k+1]),
  // lane 2k+1 taps the right child (emitted when sel[6k+2]); sel[6k] picks the bypass side.
  function automatic void fan_eval(
    input  logic [N_UNIT*DW_DATA-1:0]    prod,
    input  cfg_t                         c,
    output logic [N_BUSLINE*DW_DATA-1:0] sums,
    output logic [N_BUSLINE-1:0]         vlds
  );
    logic signed [DW_DATA-1:0] nv [2*N_UNIT];
    logic                      nok [2*N_UNIT];
    int k;
    sums = '0;
    vlds = '0;
    nv[0] = '0;
    nok[0] = 1'b0;
    for (int n = N_UNIT; n < 2*N_UNIT; n++) begin
      nok[n] = |c.edge_tag[2*(n-N_UNIT) +: 2];
      nv[n]  = nok[n] ? prod[(n-N_UNIT)*DW_DATA +: DW_DATA] : '0;
    end
    for (int n = N_UNIT - 1; n >= 1; n--) begin
      k = n - 1;
      if (c.add_en[k]) begin
        nv[n]  = wrap_add(nv[2*n], nv[2*n+1]);
        nok[n] = nok[2*n] | nok[2*n+1];
      end else if (c.bypass_en[k]) begin
        nv[n]  = c.sel[6*k] ? nv[2*n+1] : nv[2*n];
        nok[n] = c.sel[6*k] ? nok[2*n+1] : nok[2*n];
      end else begin
        nv[n]  = '0;
        nok[n] = 1'b0;
      end
      sums[(2*k)*DW_DATA +: DW_DATA]   = nv[n];
      vlds[2*k]                        = nok[n] & c.sel[6*k+1];
      sums[(2*k+1)*DW_DATA +: DW_DATA] = nv[2*n+1];
      vlds[2*k+1]                      = nok[2*n+1] & c.sel[6*k+2];
    end
  endfunction

  state_t                          state_q, state_d;
  cfg_t                            shadow_q, shadow_d, active_q, active_d;
  logic                            shadow_full_q, shadow_full_d;
  logic [N_UNIT*DW_DATA-1:0]       a_stat_q, a_stat_d;
  logic [FOLD_W-1:0]               fold_q, fold_d;
  logic                            vld_p0_q, vld_p0_d, first_p0_q, first_p0_d, last_p0_q, last_p0_d;
  logic                            vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
  logic                            vld_p2_q, vld_p2_d, first_p2_q, first_p2_d, last_p2_q, last_p2_d;
  logic                            vld_p3_q, vld_p3_d, last_p3_q, last_p3_d;
  logic [TILE_K*DW_DATA-1:0]       b_p0_q, b_p0_d;
  logic [N_UNIT*DW_DATA-1:0]       bdist_p1_q, bdist_p1_d;
  logic [N_UNIT*DW_DATA-1:0]       prod_p2_q, prod_p2_d;
  logic [N_BUSLINE*DW_DATA-1:0]    acc_q, acc_d;
  logic [N_BUSLINE-1:0]            mask_acc_q, mask_acc_d;
  logic                            out_valid_q, out_valid_d;
  logic [N_BUSLINE*DW_DATA-1:0]    out_bus_q, out_bus_d;
  logic [N_BUSLINE-1:0]            out_mask_q, out_mask_d;
  logic                            pipe_en, b_acc, is_last;
  logic [FOLD_W-1:0]               folds_eff;
  logic [N_BUSLINE*DW_DATA-1:0]    fan_sum;
  logic [N_BUSLINE-1:0]            fan_vld;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    a_stat_d      = a_stat_q;
    fold_d        = fold_q;
    vld_p0_d = vld_p0_q; first_p0_d = first_p0_q; last_p0_d = last_p0_q; b_p0_d = b_p0_q;
    vld_p1_d = vld_p1_q; first_p1_d = first_p1_q; last_p1_d = last_p1_q; bdist_p1_d = bdist_p1_q;
    vld_p2_d = vld_p2_q; first_p2_d = first_p2_q; last_p2_d = last_p2_q; prod_p2_d = prod_p2_q;
    vld_p3_d = vld_p3_q; last_p3_d = last_p3_q;
    acc_d       = acc_q;
    mask_acc_d  = mask_acc_q;
    out_valid_d = out_valid_q;
    out_bus_d   = out_bus_q;
    out_mask_d  = out_mask_q;
    fan_sum     = '0;
    fan_vld     = '0;

    pipe_en   = !(out_valid_q && !out_ready);
    b_acc     = (state_q == S_STREAM) && pipe_en && b_valid;
    folds_eff = (active_q.folds == '0) ? FOLD_W'(1) : active_q.folds;
    is_last   = (fold_q == folds_eff - FOLD_W'(1));

    unique case (state_q)
      S_IDLE: if (shadow_full_q) begin
        active_d      = shadow_q;
        shadow_full_d = 1'b0;
        state_d       = S_LOAD_A;
      end
      S_LOAD_A: if (a_valid) begin
        a_stat_d = a_data;
        fold_d   = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: if (b_acc) begin
        fold_d = fold_q + FOLD_W'(1);
        if (is_last) state_d = S_DRAIN;
      end
      S_DRAIN: if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Shadow slot is only written while empty and only promoted while full.
    if (cfg_valid && !shadow_full_q) begin
      shadow_d      = '{route: cfg_route, add_en: cfg_add_en, bypass_en: cfg_bypass_en,
                        sel: cfg_sel, edge_tag: cfg_edge_tag, folds: cfg_folds};
      shadow_full_d = 1'b1;
    end

    fan_eval(prod_p2_q, active_q, fan_sum, fan_vld);

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (pipe_en) begin
      // S0: B input register
      vld_p0_d   = b_acc;
      first_p0_d = (fold_q == '0);
      last_p0_d  = is_last;
      if (b_acc) b_p0_d = b_data;
      // S1: Benes distribution
      vld_p1_d   = vld_p0_q;
      first_p1_d = first_p0_q;
      last_p1_d  = last_p0_q;
      bdist_p1_d = benes_route(b_p0_q, active_q.route);
      // S2: multiplier array
      vld_p2_d   = vld_p1_q;
      first_p2_d = first_p1_q;
      last_p2_d  = last_p1_q;
      for (int i = 0; i < N_UNIT; i++)
        prod_p2_d[i*DW_DATA +: DW_DATA] = wrap_mul(a_stat_q[i*DW_DATA +: DW_DATA],
                                                   bdist_p1_q[i*DW_DATA +: DW_DATA]);
      // S3: FAN reduction into the accumulators
      vld_p3_d  = vld_p2_q;
      last_p3_d = last_p2_q;
      if (vld_p2_q) begin
        for (int l = 0; l < N_BUSLINE; l++)
          if (fan_vld[l])
            acc_d[l*DW_DATA +: DW_DATA] = first_p2_q ? fan_sum[l*DW_DATA +: DW_DATA]
                                        : wrap_add(acc_q[l*DW_DATA +: DW_DATA],
                                                   fan_sum[l*DW_DATA +: DW_DATA]);
        mask_acc_d = first_p2_q ? fan_vld : (mask_acc_q | fan_vld);
      end
      // Output register: the retiring last beat publishes the tile result
      if (vld_p3_q && last_p3_q) begin
        out_valid_d = 1'b1;
        out_bus_d   = acc_q;
        out_mask_d  = mask_acc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shadow_full_q <= 1'b0;
      fold_q        <= '0;
      vld_p0_q      <= 1'b0;
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      vld_p3_q      <= 1'b0;
      acc_q         <= '0;
      mask_acc_q    <= '0;
      out_valid_q   <= 1'b0;
      out_bus_q     <= '0;
      out_mask_q    <= '0;
    end else begin
      state_q       <= state_d;
      shadow_full_q <= shadow_full_d;
      fold_q        <= fold_d;
      vld_p0_q      <= vld_p0_d;
      vld_p1_q      <= vld_p1_d;
      vld_p2_q      <= vld_p2_d;
      vld_p3_q      <= vld_p3_d;
      acc_q         <= acc_d;
      mask_acc_q    <= mask_acc_d;
      out_valid_q   <= out_valid_d;
      out_bus_q     <= out_bus_d;
      out_mask_q    <= out_mask_d;
    end
  end

  always_ff @(posedge clk) begin
    shadow_q   <= shadow_d;
    active_q   <= active_d;
    a_stat_q   <= a_stat_d;
    first_p0_q <= first_p0_d;
    last_p0_q  <= last_p0_d;
    b_p0_q     <= b_p0_d;
    first_p1_q <= first_p1_d;
    last_p1_q  <= last_p1_d;
    bdist_p1_q <= bdist_p1_d;
    first_p2_q <= first_p2_d;
    last_p2_q  <= last_p2_d;
    prod_p2_q  <= prod_p2_d;
    last_p3_q  <= last_p3_d;
  end

  assign cfg_ready = !shadow_full_q;
  assign a_ready   = (state_q == S_LOAD_A);
  assign b_ready   = (state_q == S_STREAM) && pipe_en;
  assign out_valid = out_valid_q;
  assign out_bus   = out_bus_q;
  assign out_mask  = out_mask_q;
  assign busy      = (state_q != S_IDLE) || vld_p0_q || vld_p1_q || vld_p2_q || vld_p3_q
                     || out_valid_q;

endmodule

// File: tb/tb_ustc_stream_array.sv
// Directed bench for ustc_stream_array: leaf-level FAN adders sum product pairs into the
// even lanes 30..60; results are checked lane by lane against hand-derived values.
`timescale 1ns/1ps
module tb_ustc_stream_array;
  localparam int N_UNIT = 32;
  localparam int DW     = 32;
  localparam int TILE_K = 8;
  localparam int N_ADD  = 31;
  localparam int N_BUS  = 62;
  localparam int N_LEV  = 9;
  localparam int FOLD_W = 8;
  localparam int WAIT_MAX = 50;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    cfg_valid, cfg_ready;
  logic [N_LEV*N_UNIT-1:0] cfg_route;
  logic [N_ADD-1:0]        cfg_add_en, cfg_bypass_en;
  logic [6*N_ADD-1:0]      cfg_sel;
  logic [2*N_UNIT-1:0]     cfg_edge_tag;
  logic [FOLD_W-1:0]       cfg_folds;
  logic                    a_valid, a_ready;
  logic [N_UNIT*DW-1:0]    a_data;
  logic                    b_valid, b_ready;
  logic [TILE_K*DW-1:0]    b_data;
  logic                    out_valid, out_ready;
  logic [N_BUS*DW-1:0]     out_bus;
  logic [N_BUS-1:0]        out_mask;
  logic                    busy;

  ustc_stream_array dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_route(cfg_route),
    .cfg_add_en(cfg_add_en), .cfg_bypass_en(cfg_bypass_en), .cfg_sel(cfg_sel),
    .cfg_edge_tag(cfg_edge_tag), .cfg_folds(cfg_folds),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
    .out_mask(out_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  always @(negedge clk) if (out_valid && out_ready) n_out++;

  logic [N_BUS-1:0]        exp_mask;
  logic [DW-1:0]           exp_lane [N_BUS];
  logic [N_LEV*N_UNIT-1:0] route_id, route_sw;
  logic [N_UNIT*DW-1:0]    a_pair;
  logic [TILE_K*DW-1:0]    b_seq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_UNIT*DW-1:0] rep_a(input logic [DW-1:0] v);
    logic [N_UNIT*DW-1:0] r;
    for (int i = 0; i < N_UNIT; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [TILE_K*DW-1:0] rep_b(input logic [DW-1:0] v);
    logic [TILE_K*DW-1:0] r;
    for (int j = 0; j < TILE_K; j++) r[j*DW +: DW] = v;
    return r;
  endfunction

  // Masked lanes all take the same value, the rest stay 0.
  task automatic set_exp(input logic [DW-1:0] v);
    for (int l = 0; l < N_BUS; l++) exp_lane[l] = exp_mask[l] ? v : '0;
  endtask

  task automatic check_bus(input string tag);
    chk({tag, "_mask"}, 64'(out_mask), 64'(exp_mask));
    for (int l = 0; l < N_BUS; l++)
      chk($sformatf("%s_lane%0d", tag, l), 64'(out_bus[l*DW +: DW]), 64'(exp_lane[l]));
  endtask

  task automatic send_cfg(input logic [N_LEV*N_UNIT-1:0] route, input logic [FOLD_W-1:0] folds);
    int w = 0;
    cfg_route = route;
    cfg_folds = folds;
    cfg_valid = 1'b1;
    while (!cfg_ready && w < WAIT_MAX) begin tick(); w++; end
    chk("cfg_handshake_timeout", 64'(w < WAIT_MAX), 64'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_a(input logic [N_UNIT*DW-1:0] d);
    int w = 0;
    a_data  = d;
    a_valid = 1'b1;
    while (!a_ready && w < WAIT_MAX) begin tick(); w++; end
    chk("a_handshake_timeout", 64'(w < WAIT_MAX), 64'd1);
    tick();
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [TILE_K*DW-1:0] d);
    int w = 0;
    b_data  = d;
    b_valid = 1'b1;
    while (!b_ready && w < WAIT_MAX) begin tick(); w++; end
    chk("b_handshake_timeout", 64'(w < WAIT_MAX), 64'd1);
    tick();
    b_valid = 1'b0;
  endtask

  task automatic wait_out();
    int w = 0;
    while (!out_valid && w < WAIT_MAX) begin tick(); w++; end
    chk("out_valid_timeout", 64'(w < WAIT_MAX), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    cfg_valid = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = '0; b_data = '0; cfg_folds = '0;
    route_id = '0;
    route_sw = '0;
    route_sw[4*N_UNIT + 0] = 1'b1;   // level 4 exchanges index bit 0: swaps ports 0 and 1
    cfg_route = route_id;
    cfg_add_en = '0; cfg_bypass_en = '0; cfg_sel = '0;
    cfg_edge_tag = {N_UNIT{2'b01}};
    exp_mask = '0;
    for (int k = 15; k < 31; k++) begin
      cfg_add_en[k]    = 1'b1;
      cfg_sel[6*k + 1] = 1'b1;
      exp_mask[2*k]    = 1'b1;
    end
    a_pair = '0;
    a_pair[0*DW +: DW] = 32'd1;
    a_pair[1*DW +: DW] = 32'd2;
    for (int j = 0; j < TILE_K; j++) b_seq[j*DW +: DW] = DW'(j + 1);

    // Reset held 3 cycles with a_valid/b_valid asserted
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_bus_or", 64'(|out_bus), 64'd0);
    chk("rst_out_mask", 64'(out_mask), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Identity route, one fold: 2*3 + 2*3 = 12 per pair lane, 4-cycle latency
    send_cfg(route_id, 8'd1);
    send_a(rep_a(32'd2));
    chk("stream_b_ready", 64'(b_ready), 64'd1);
    send_b(rep_b(32'd3));
    chk("lat_c0", 64'(out_valid), 64'd0);
    tick(); chk("lat_c1", 64'(out_valid), 64'd0);
    tick(); chk("lat_c2", 64'(out_valid), 64'd0);
    tick(); chk("lat_c3", 64'(out_valid), 64'd0);
    tick(); chk("lat_c4", 64'(out_valid), 64'd1);
    set_exp(32'd12);
    check_bus("t2");
    tick();
    chk("t2_busy_after", 64'(busy), 64'd0);
    chk("t2_n_out", 64'(n_out), 64'd1);

    // Four folds with bubbles: 4*(1+2+3+4) = 40
    send_cfg(route_id, 8'd4);
    send_a(rep_a(32'd2));
    for (int v = 1; v <= 3; v++) begin
      send_b(rep_b(DW'(v)));
      tick();
      tick();
      chk("t3_no_early_out", 64'(out_valid), 64'd0);
    end
    send_b(rep_b(32'd4));
    wait_out();
    set_exp(32'd40);
    check_bus("t3");
    tick();
    repeat (3) tick();
    chk("t3_n_out", 64'(n_out), 64'd2);

    // Backpressure: result held for 5 cycles
    out_ready = 1'b0;
    send_cfg(route_id, 8'd1);
    send_a(rep_a(32'd2));
    send_b(rep_b(32'd3));
    wait_out();
    set_exp(32'd12);
    check_bus("t4_first");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_b_ready", 64'(b_ready), 64'd0);
      chk("t4_hold_busy", 64'(busy), 64'd1);
      chk("t4_hold_lane30", 64'(out_bus[30*DW +: DW]), 64'd12);
      chk("t4_hold_mask", 64'(out_mask), 64'(exp_mask));
    end
    chk("t4_n_out_held", 64'(n_out), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("t4_released", 64'(out_valid), 64'd0);
    chk("t4_n_out", 64'(n_out), 64'd3);
    // Next tile, folds=0 acts as one fold: 2*5 + 2*5 = 20
    send_cfg(route_id, 8'd0);
    send_a(rep_a(32'd2));
    send_b(rep_b(32'd5));
    wait_out();
    set_exp(32'd20);
    check_bus("t4_next");
    tick();
    chk("t4_next_busy", 64'(busy), 64'd0);
    repeat (4) tick();
    chk("t4_next_n_out", 64'(n_out), 64'd4);

    // Second config arrives mid-tile and waits in the shadow slot
    send_cfg(route_id, 8'd1);
    send_a(a_pair);
    chk("t5_shadow_free", 64'(cfg_ready), 64'd1);
    send_cfg(route_sw, 8'd1);
    chk("t5_shadow_full", 64'(cfg_ready), 64'd0);
    chk("t5_still_stream", 64'(b_ready), 64'd1);
    send_b(b_seq);
    wait_out();
    set_exp(32'd0);
    exp_lane[30] = 32'd5;            // 1*1 + 2*2 through the identity route
    check_bus("t5_tile1");
    chk("t5_shadow_waits", 64'(cfg_ready), 64'd0);
    tick();
    tick();
    chk("t5_promoted", 64'(cfg_ready), 64'd1);
    chk("t5_load_a", 64'(a_ready), 64'd1);
    send_a(a_pair);
    send_b(b_seq);
    wait_out();
    exp_lane[30] = 32'd4;            // 1*2 + 2*1 with ports 0 and 1 swapped
    check_bus("t5_tile2");
    tick();
    chk("t5_n_out", 64'(n_out), 64'd6);

    // Wrap: 0x7FFFFFFF*2 = 0xFFFFFFFE per unit, pair -4, two folds -8
    send_cfg(route_id, 8'd2);
    send_a(rep_a(32'h7FFF_FFFF));
    send_b(rep_b(32'd2));
    send_b(rep_b(32'd2));
    wait_out();
    set_exp(32'hFFFF_FFF8);
    check_bus("t6_wrap");
    tick();
    chk("t6_n_out", 64'(n_out), 64'd7);
    // Reset with a beat in flight drops the tile
    send_cfg(route_id, 8'd2);
    send_a(rep_a(32'd2));
    send_b(rep_b(32'd3));
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("t6_rst_mask", 64'(out_mask), 64'd0);
    chk("t6_rst_bus_or", 64'(|out_bus), 64'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t6_no_out_after_rst", 64'(out_valid), 64'd0);
    end
    chk("t6_final_n_out", 64'(n_out), 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
